mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder.sv | 135 +++++++++++++
 tb/tb_mem_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU-side req/ack bus of the memory responder.
// The CPU drives through master; the responder answers through slave.
`ifndef WORD
`define WORD 16
`endif

interface mem_responder_if;
    logic             req;
    logic             we;
    logic [7:0]       addr;
    logic [`WORD-1:0] wdata;
    logic             ack;
    logic [`WORD-1:0] rdata;
    logic             busy;
    logic             err;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word memory answering CPU requests after fixed wait states.
// Define MEM_WAIT_EN to enable the WAIT state and the WAIT_CYCLES counter.
`ifndef WORD
`define WORD 16
`endif

module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    mem_responder_if.slave bus
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    if (DEPTH < 1 || DEPTH > 256) begin : g_bad_depth
        $error("mem_responder: DEPTH must be 1..256");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_responder: WAIT_CYCLES must be 0..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           state, state_nx;
    logic             we_q;
    logic [7:0]       addr_q;
    logic [`WORD-1:0] wdata_q;
    logic [`WORD-1:0] rdata_q;
    logic             err_q;
    logic [`WORD-1:0] mem [DEPTH];

    logic             op_we;
    logic [7:0]       op_addr;
    logic [`WORD-1:0] op_wdata;
    logic             in_range;
    logic             resp_go;
    logic [AW-1:0]    idx;

`ifdef MEM_WAIT_EN
    logic [3:0]       cnt, cnt_nx;
`endif

    // Without wait states RESP is entered on the sampling edge itself,
    // so the operation must come straight from the bus in IDLE.
    always_comb begin
        op_we    = we_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        if (state == S_IDLE) begin
            op_we    = bus.we;
            op_addr  = bus.addr;
            op_wdata = bus.wdata;
        end
    end

    assign in_range = {1'b0, op_addr} < DEPTH_W;
    assign idx      = op_addr[AW-1:0];
    assign resp_go  = (state != S_RESP) && (state_nx == S_RESP);

    always_comb begin
        state_nx = state;
`ifdef MEM_WAIT_EN
        cnt_nx   = cnt;
`endif
        unique case (state)
            S_IDLE: begin
                if (bus.req) begin
`ifdef MEM_WAIT_EN
                    cnt_nx   = 4'(WAIT_CYCLES);
                    state_nx = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
`else
                    state_nx = S_RESP;
`endif
                end
            end
`ifdef MEM_WAIT_EN
            S_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = S_RESP;
                end
            end
`endif
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MEM_WAIT_EN
            cnt     <= '0;
`endif
        end else begin
            state <= state_nx;
`ifdef MEM_WAIT_EN
            cnt   <= cnt_nx;
`endif
            if (state == S_IDLE && bus.req) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (resp_go) begin
                err_q <= !in_range;
                if (!in_range) begin
                    rdata_q <= '0;
                end else if (!op_we) begin
                    rdata_q <= mem[idx];
                end
            end
        end
    end

    // Storage has no reset; a reset edge simply blocks the commit.
    always_ff @(posedge clk) begin
        if (rst_n && resp_go && op_we && in_range) begin
            mem[idx] <= op_wdata;
        end
    end

    assign bus.ack   = (state == S_RESP);
    assign bus.busy  = (state != S_IDLE);
    assign bus.err   = bus.ack && err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: random and directed traffic against a timeline model
// of the responder, compared on every falling edge.
`ifndef WORD
`define WORD 16
`endif

module tb_mem_responder;
    localparam int DEPTH = 128;
    localparam int WC    = 2;
`ifdef MEM_WAIT_EN
    localparam int L = WC;
`else
    localparam int L = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_responder_if bus ();
    mem_responder_if bus0 ();

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    mem_responder #(.DEPTH(4), .WAIT_CYCLES(0)) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [`WORD-1:0] init_val(input logic [7:0] a);
        return `WORD'({~a, a});
    endfunction

    // Timeline model: a request sampled at edge s completes at edge s+L,
    // and the next request can be sampled no earlier than s+L+2.
    int               edge_n  = 0;
    int               s_at    = -10;
    int               ack_at  = -10;
    int               next_ok = 0;
    bit               mvalid  = 0;
    logic             m_we;
    logic [7:0]       m_addr;
    logic [`WORD-1:0] m_wdata;
    logic [`WORD-1:0] mem_m [256];
    bit               known [256];
    logic             e_ack, e_busy, e_err;
    logic [`WORD-1:0] e_rdata;
    bit               e_rk;

    always @(posedge clk) begin
        edge_n++;
        if (!rst_n) begin
            s_at    = -10;
            ack_at  = -10;
            next_ok = edge_n + 1;
            e_rdata = '0;
            e_rk    = 1;
            mvalid  = 1;
        end else begin
            if (edge_n >= next_ok && bus.req) begin
                m_we    = bus.we;
                m_addr  = bus.addr;
                m_wdata = bus.wdata;
                s_at    = edge_n;
                ack_at  = edge_n + L;
                next_ok = ack_at + 2;
            end
            if (edge_n == ack_at) begin
                if (int'(m_addr) < DEPTH) begin
                    if (m_we) begin
                        mem_m[m_addr] = m_wdata;
                        known[m_addr] = 1;
                    end else begin
                        e_rdata = mem_m[m_addr];
                        e_rk    = known[m_addr];
                    end
                end else begin
                    e_rdata = '0;
                    e_rk    = 1;
                end
            end
        end
        e_ack  = rst_n && (edge_n == ack_at);
        e_busy = rst_n && (edge_n >= s_at) && (edge_n <= ack_at);
        e_err  = e_ack && (int'(m_addr) >= DEPTH);
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("ack", 32'(bus.ack), 32'(e_ack));
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("err", 32'(bus.err), 32'(e_err));
            if (e_rk) chk("rdata", 32'(bus.rdata), 32'(e_rdata));
        end
    end

    task automatic do_txn(input logic w, input logic [7:0] a,
                          input logic [`WORD-1:0] d,
                          output logic [`WORD-1:0] rd, output logic er,
                          output int lat);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (bus.ack) begin
                rd = bus.rdata;
                er = bus.err;
                return;
            end
            bus.addr  = 8'($urandom);
            bus.wdata = `WORD'($urandom);
            bus.we    = 1'($urandom);
        end
        n_total++;
        $display("FAIL ack_timeout: no ack for addr 0x%0h, expected within 40", a);
    endtask

    initial begin
        logic [`WORD-1:0] rd;
        logic             er;
        int               lat;
        int               acks[$];
        int               busy_low;

        rst_n      = 1'b0;
        bus.req    = 1'b0;
        bus.we     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus0.req   = 1'b0;
        bus0.we    = 1'b0;
        bus0.addr  = '0;
        bus0.wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_rdata", 32'(bus.rdata), 0);
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            do_txn(1'b1, 8'(a), init_val(8'(a)), rd, er, lat);
        end

        do_txn(1'b1, 8'd5, `WORD'(16'h1234), rd, er, lat);
        chk("wr5_latency", 32'(lat), 32'(L + 1));
        do_txn(1'b0, 8'd5, '0, rd, er, lat);
        chk("rd5_latency", 32'(lat), 32'(L + 1));
        chk("rd5_data", 32'(rd), 32'h1234);
        chk("rd5_err", 32'(er), 0);

        do_txn(1'b1, 8'h80, `WORD'(16'hDEAD), rd, er, lat);
        chk("wr80_err", 32'(er), 1);
        do_txn(1'b0, 8'h80, '0, rd, er, lat);
        chk("rd80_err", 32'(er), 1);
        chk("rd80_data", 32'(rd), 0);
        do_txn(1'b0, 8'h00, '0, rd, er, lat);
        chk("rd00_alias", 32'(rd), 32'(init_val(8'h00)));

        do_txn(1'b1, 8'd9, `WORD'(16'h5A5A), rd, er, lat);
        do_txn(1'b0, 8'd9, '0, rd, er, lat);
        chk("rd9_scrambled", 32'(rd), 32'h5A5A);

        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 8'd7;
        bus.wdata = `WORD'(16'hBEEF);
`ifdef MEM_WAIT_EN
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        rst_n   = 1'b0;
`else
        rst_n = 1'b0;
`endif
        @(negedge clk);
        bus.req = 1'b0;
        chk("abort_ack", 32'(bus.ack), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_err", 32'(bus.err), 0);
        chk("abort_rdata", 32'(bus.rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1'b0, 8'd7, '0, rd, er, lat);
        chk("rd7_old", 32'(rd), 32'(init_val(8'd7)));

        busy_low = 0;
        @(negedge clk);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 8'd3;
        for (int c = 0; c < 100 && acks.size() < 4; c++) begin
            @(negedge clk);
            if (bus.ack) acks.push_back(c);
            else if (acks.size() > 0 && !bus.busy) busy_low++;
        end
        bus.req = 1'b0;
        chk("b2b_count", 32'(acks.size()), 4);
        for (int k = 1; k < acks.size(); k++) begin
            chk("b2b_gap", 32'(acks[k] - acks[k-1]), 32'(L + 2));
        end
        chk("b2b_idle", 32'(busy_low), 3);

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 149) != 0);
            bus.req   = 1'($urandom);
            bus.we    = 1'($urandom);
            bus.addr  = 8'($urandom_range(0, 159));
            bus.wdata = `WORD'($urandom);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 1'b0;
        repeat (L + 3) @(negedge clk);

        bus0.req  = 1'b1;
        bus0.we   = 1'b0;
        bus0.addr = 8'd9;
        @(negedge clk);
        bus0.req = 1'b0;
        chk("w0_ack", 32'(bus0.ack), 1);
        chk("w0_busy", 32'(bus0.busy), 1);
        chk("w0_err", 32'(bus0.err), 1);
        chk("w0_rdata", 32'(bus0.rdata), 0);
        @(negedge clk);
        chk("w0_ack_low", 32'(bus0.ack), 0);
        chk("w0_busy_low", 32'(bus0.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
